// File: rtl/bcd_timekeeper.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_timekeeper
//  Purpose  : BCD time-of-day counter with internal 1 Hz prescaler,
//             12h/24h hour format and a mode/inc button set state machine.
//  Ports    : clk, rst (async, active high)
//             mode_btn, inc_btn  - clk-synchronous debounced levels
//             sec, min, hour     - packed BCD time fields
//             pm                 - PM flag (12h format only)
//             state              - 00 RUN, 01 SET_HOUR, 10 SET_MIN
//             tick_1hz, day_roll - single-cycle pulses
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_timekeeper #(
    parameter int CLK_DIV        = 50_000_000,
    parameter bit H24            = 1'b1,
    parameter bit SET_CLEARS_SEC = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic       pm,
    output logic [1:0] state,
    output logic       tick_1hz,
    output logic       day_roll
);

    localparam int               c_PW          = $clog2(CLK_DIV);
    localparam logic [c_PW-1:0]  c_PRESC_MAX   = c_PW'(CLK_DIV - 1);
    localparam logic [7:0]       c_HOUR_RST    = H24 ? 8'h00 : 8'h12;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10,
        ST_ILLEGAL  = 2'b11
    } state_t;

    state_t            r_state;
    logic [c_PW-1:0]   r_presc;
    logic [7:0]        r_sec, r_min, r_hour;
    logic              r_pm, r_tick, r_day_roll;
    logic              r_mode_q, r_inc_q;

    state_t            w_state_n;
    logic [c_PW-1:0]   w_presc_n;
    logic [7:0]        w_sec_n, w_min_n, w_hour_n;
    logic              w_pm_n, w_day_roll_n;
    logic [8:0]        w_hour_inc;
    logic              w_mode_edge, w_inc_edge;

    // Two-digit BCD increment with 59 -> 00 wrap.
    function automatic logic [7:0] f_inc60(input logic [7:0] v);
        if (v == 8'h59)
            return 8'h00;
        else if (v[3:0] == 4'h9)
            return {v[7:4] + 4'h1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'h1};
    endfunction

    // Hour increment, returns {pm_next, hour_next}.
    // 24h: 23 -> 00. 12h: 12 -> 01, and 11 -> 12 flips AM/PM.
    function automatic logic [8:0] f_inc_hour(input logic [7:0] h, input logic p);
        logic [7:0] bcd_next;
        bcd_next = (h[3:0] == 4'h9) ? {h[7:4] + 4'h1, 4'h0} : {h[7:4], h[3:0] + 4'h1};
        if (H24) begin
            return (h == 8'h23) ? 9'h000 : {1'b0, bcd_next};
        end else begin
            if (h == 8'h12)
                return {p, 8'h01};
            else if (h == 8'h11)
                return {~p, 8'h12};
            else
                return {p, bcd_next};
        end
    endfunction

    assign w_mode_edge = mode_btn & ~r_mode_q;
    assign w_inc_edge  = inc_btn  & ~r_inc_q;
    assign w_hour_inc  = f_inc_hour(r_hour, r_pm);

    always_comb begin
        w_state_n    = r_state;
        w_sec_n      = r_sec;
        w_min_n      = r_min;
        w_hour_n     = r_hour;
        w_pm_n       = r_pm;
        w_day_roll_n = 1'b0;
        w_presc_n    = (r_presc == c_PRESC_MAX) ? '0 : r_presc + c_PW'(1);

        case (r_state)
            ST_RUN: begin
                if (w_mode_edge)
                    w_state_n = ST_SET_HOUR;
                // Time advance uses the registered tick, so the second
                // changes on the edge where tick_1hz is visibly high.
                if (r_tick) begin
                    w_sec_n = f_inc60(r_sec);
                    if (r_sec == 8'h59) begin
                        w_min_n = f_inc60(r_min);
                        if (r_min == 8'h59) begin
                            {w_pm_n, w_hour_n} = w_hour_inc;
                            w_day_roll_n = H24 ? (r_hour == 8'h23)
                                               : (r_hour == 8'h11) && r_pm;
                        end
                    end
                end
            end
            ST_SET_HOUR: begin
                if (w_mode_edge)
                    w_state_n = ST_SET_MIN;
                else if (w_inc_edge)
                    {w_pm_n, w_hour_n} = w_hour_inc;
            end
            ST_SET_MIN: begin
                if (w_mode_edge) begin
                    w_state_n = ST_RUN;
                    // Restart the second cleanly so the user-set minute
                    // begins at :00 with a full second before the first tick.
                    if (SET_CLEARS_SEC) begin
                        w_sec_n   = 8'h00;
                        w_presc_n = '0;
                    end
                end else if (w_inc_edge) begin
                    w_min_n = f_inc60(r_min);
                end
            end
            default: w_state_n = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_presc    <= '0;
            r_sec      <= 8'h00;
            r_min      <= 8'h00;
            r_hour     <= c_HOUR_RST;
            r_pm       <= 1'b0;
            r_tick     <= 1'b0;
            r_day_roll <= 1'b0;
            r_mode_q   <= 1'b0;
            r_inc_q    <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_presc    <= w_presc_n;
            r_sec      <= w_sec_n;
            r_min      <= w_min_n;
            r_hour     <= w_hour_n;
            r_pm       <= w_pm_n;
            // Registered tick mirrors the prescaler's terminal count.
            r_tick     <= (w_presc_n == c_PRESC_MAX);
            r_day_roll <= w_day_roll_n;
            r_mode_q   <= mode_btn;
            r_inc_q    <= inc_btn;
        end
    end

    assign sec      = r_sec;
    assign min      = r_min;
    assign hour     = r_hour;
    assign pm       = r_pm;
    assign state    = r_state;
    assign tick_1hz = r_tick;
    assign day_roll = r_day_roll;

endmodule
`default_nettype wire
